// File: rtl/dsm_ef2.sv
// Second-order error-feedback sigma-delta requantizer, NTF = (1 - z^-1)^2, with overload recovery.
// Optional 1-bit LFSR dither is enabled by defining DSM_DITHER_EN.
//
// state   | meaning
// --------+----------------------------------------------------------
// RUN     | normal noise shaping, counting consecutive saturated samples
// RECOVER | one cycle: feedback state and counter cleared, then RUN

module dsm_ef2 #(
   parameter int gp_idata_width = 16,
   parameter int gp_odata_width = 4,
   parameter int gp_ovl_limit   = 8
) (
   input  logic                             i_clk,
   input  logic                             i_rst_an,
   input  logic                             i_ena,
   input  logic                             i_valid,
   input  logic signed [gp_idata_width-1:0] i_data,
   output logic                             o_valid,
   output logic signed [gp_odata_width-1:0] o_data,
   output logic                             o_ovl,
   input  logic                             i_ovl_clr
);

   localparam int W  = gp_idata_width;
   localparam int O  = gp_odata_width;
   localparam int S  = W - O;
   localparam int VW = W + 3;
   localparam int CW = $clog2(gp_ovl_limit + 1);

   localparam logic signed [VW-1:0] VMAX = {{4{1'b0}}, {(W-1){1'b1}}};
   localparam logic signed [VW-1:0] VMIN = {{4{1'b1}}, {(W-1){1'b0}}};
   localparam logic [CW-1:0]        OVL_LIMIT = CW'(gp_ovl_limit);

   typedef enum logic {RUN, RECOVER} state_t;

   state_t                state_q;
   logic signed [W-1:0]   e1_q;
   logic signed [W-1:0]   e2_q;
   logic [CW-1:0]         cnt_q;

   logic                  accept;
   logic signed [W-1:0]   fb1;
   logic signed [W-1:0]   fb2;
   logic signed [VW-1:0]  v;
   logic signed [W-1:0]   vs;
   logic                  sat;
   logic signed [O-1:0]   q;
   logic signed [W-1:0]   e;
   logic [CW-1:0]         cnt_nxt;
   logic                  ovl_set;

   assign accept = i_ena & i_valid;

`ifdef DSM_DITHER_EN
   logic [15:0] lfsr_q;

   always_ff @(posedge i_clk or negedge i_rst_an) begin
      if (!i_rst_an) begin
         lfsr_q <= 16'hACE1;
      end else if (accept) begin
         lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      end
   end
`endif

   always_comb begin
      fb1 = e1_q;
      fb2 = e2_q;
      // A sample arriving during RECOVER already sees the cleared state.
      if (state_q == RECOVER) begin
         fb1 = '0;
         fb2 = '0;
      end

      v = {{3{i_data[W-1]}}, i_data}
        - {{2{fb1[W-1]}}, fb1, 1'b0}
        + {{3{fb2[W-1]}}, fb2};
`ifdef DSM_DITHER_EN
      v = v + {{(VW-S){1'b0}}, lfsr_q[0], {(S-1){1'b0}}};
`endif

      if (v > VMAX) begin
         vs  = VMAX[W-1:0];
         sat = 1'b1;
      end else if (v < VMIN) begin
         vs  = VMIN[W-1:0];
         sat = 1'b1;
      end else begin
         vs  = v[W-1:0];
         sat = 1'b0;
      end

      q = vs[W-1:S];
      // Always in [-(2^S-1), 0], so W bits never wrap.
      e = $signed({q, {S{1'b0}}}) - vs;

      cnt_nxt = sat ? cnt_q + CW'(1) : '0;
      ovl_set = (state_q == RUN) && accept && (cnt_nxt == OVL_LIMIT);
   end

   always_ff @(posedge i_clk or negedge i_rst_an) begin
      if (!i_rst_an) begin
         state_q <= RUN;
         e1_q    <= '0;
         e2_q    <= '0;
         cnt_q   <= '0;
         o_valid <= 1'b0;
         o_data  <= '0;
         o_ovl   <= 1'b0;
      end else begin
         o_valid <= accept;
         if (i_ena) begin
            if (accept) begin
               o_data <= q;
            end

            case (state_q)
               RUN: begin
                  if (accept) begin
                     e2_q  <= e1_q;
                     e1_q  <= e;
                     cnt_q <= cnt_nxt;
                     if (cnt_nxt == OVL_LIMIT) begin
                        state_q <= RECOVER;
                     end
                  end
               end
               RECOVER: begin
                  cnt_q   <= '0;
                  state_q <= RUN;
                  e2_q    <= '0;
                  if (accept) begin
                     e1_q <= e;
                  end else begin
                     e1_q <= '0;
                  end
               end
               default: state_q <= RUN;
            endcase

            if (ovl_set) begin
               o_ovl <= 1'b1;
            end else if (i_ovl_clr) begin
               o_ovl <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_dsm_ef2.sv
// Self-checking bench for dsm_ef2: hand-computed vector table, scoreboard against
// a behavioural integer model, and directed overload / enable / reset sequences.
module tb_dsm_ef2;

   localparam int W   = 16;
   localparam int O   = 4;
   localparam int S   = W - O;
   localparam int LIM = 8;

   logic                  clk = 1'b0;
   logic                  rst_an;
   logic                  ena;
   logic                  valid;
   logic signed [W-1:0]   din;
   logic                  o_valid;
   logic signed [O-1:0]   o_data;
   logic                  o_ovl;
   logic                  ovl_clr;

   int checks = 0;
   int errors = 0;

   int m_e1, m_e2, m_cnt;
   bit m_rec, m_ovl;
   bit exp_valid;
   bit sb_model;
   int exp_q[$];
   int sum_out;

   typedef struct {
      int din;
      int q0;
      int q1;
      int q2;
   } vec_t;

   vec_t tbl[7];

   dsm_ef2 #(
      .gp_idata_width(W),
      .gp_odata_width(O),
      .gp_ovl_limit  (LIM)
   ) dut (
      .i_clk    (clk),
      .i_rst_an (rst_an),
      .i_ena    (ena),
      .i_valid  (valid),
      .i_data   (din),
      .o_valid  (o_valid),
      .o_data   (o_data),
      .o_ovl    (o_ovl),
      .i_ovl_clr(ovl_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_e1 = 0; m_e2 = 0; m_cnt = 0; m_rec = 0; m_ovl = 0;
      exp_valid = 0;
      exp_q.delete();
   endtask

   // Behavioural reference of one clock edge.
   task automatic model_edge(input int x, input bit vld, input bit en, input bit clr);
      int v, vs, q, e;
      bit sat, set;
      exp_valid = vld && en;
      if (!en) return;
      set = 0;
      if (vld) begin
         v   = m_rec ? x : x - 2 * m_e1 + m_e2;
         vs  = (v > 32767) ? 32767 : (v < -32768) ? -32768 : v;
         sat = (vs != v);
         q   = vs >>> S;
         e   = q * (1 << S) - vs;
         if (sb_model) exp_q.push_back(q);
         if (m_rec) begin
            m_e2 = 0; m_e1 = e; m_cnt = 0; m_rec = 0;
         end else begin
            m_e2 = m_e1; m_e1 = e;
            m_cnt = sat ? m_cnt + 1 : 0;
            if (m_cnt == LIM) begin
               m_rec = 1;
               set = 1;
            end
         end
      end else if (m_rec) begin
         m_e1 = 0; m_e2 = 0; m_cnt = 0; m_rec = 0;
      end
      if (set) m_ovl = 1;
      else if (clr) m_ovl = 0;
   endtask

   task automatic cyc(input int x, input bit vld, input bit en, input bit clr);
      din = 16'(x); valid = vld; ena = en; ovl_clr = clr;
      @(posedge clk);
      model_edge(x, vld, en, clr);
      #1;
   endtask

   task automatic do_reset();
      rst_an = 1'b0;
      model_reset();
      valid = 0; ena = 0; ovl_clr = 0; din = '0;
      repeat (2) @(posedge clk);
      #1 rst_an = 1'b1;
   endtask

   always @(negedge clk) begin
      chk("o_valid", int'(o_valid), int'(exp_valid));
      if (o_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL o_data_unexpected actual=%0d expected=none", o_data);
         end else begin
            chk("o_data", int'(o_data), exp_q.pop_front());
         end
         sum_out += int'(o_data);
      end
      chk("o_ovl", int'(o_ovl), int'(m_ovl));
   end

   initial begin
      int hold_d, hold_e1, hold_cnt;
      tbl[0] = '{0,      0,  0, 0};
      tbl[1] = '{1000,   0,  0, 1};
      tbl[2] = '{32767,  7,  7, 7};
      tbl[3] = '{-32768, -8, -8, -8};
      tbl[4] = '{4096,   1,  1, 1};
      tbl[5] = '{-1,     -1, 1, 0};
      tbl[6] = '{2048,   0,  1, 1};

      sb_model = 1;
      sum_out  = 0;
      do_reset();
      chk("rst_o_data", int'(o_data), 0);
      chk("rst_o_valid", int'(o_valid), 0);
      chk("rst_o_ovl", int'(o_ovl), 0);

      // Hand-computed first three outputs from power-up state.
      sb_model = 0;
      foreach (tbl[i]) begin
         do_reset();
         cyc(tbl[i].din, 1, 1, 0); exp_q.push_back(tbl[i].q0);
         cyc(tbl[i].din, 1, 1, 0); exp_q.push_back(tbl[i].q1);
         cyc(tbl[i].din, 1, 1, 0); exp_q.push_back(tbl[i].q2);
         cyc(0, 0, 1, 0);
      end
      sb_model = 1;

      do_reset();
      for (int i = 0; i < 20; i++) cyc(0, 1, 1, 0);
      cyc(0, 0, 1, 0);

      // Constant 1000: internal error sequence, then long-run mean.
      do_reset();
      cyc(1000, 1, 1, 0);
      chk("e_1000_s1", int'(dut.e1_q), -1000);
      cyc(1000, 1, 1, 0);
      chk("e_1000_s2", int'(dut.e1_q), -3000);
      cyc(1000, 1, 1, 0);
      chk("e_1000_s3", int'(dut.e1_q), -1904);
      chk("e2_1000_s3", int'(dut.e2_q), -3000);
      for (int i = 3; i < 4096; i++) cyc(1000, 1, 1, 0);
      sum_out = 0;
      for (int i = 0; i < 4096; i++) cyc(1000, 1, 1, 0);
      cyc(1000, 0, 1, 0);
      checks++;
      if (sum_out < 997 || sum_out > 1003) begin
         errors++;
         $display("FAIL sum_4096 actual=%0d expected=1000+-3", sum_out);
      end

      // Enable low mid-stream: everything holds, no output strobes.
      for (int i = 0; i < 7; i++) cyc(1000, 1, 1, 0);
      hold_d = int'(o_data); hold_e1 = int'(dut.e1_q); hold_cnt = int'(dut.cnt_q);
      for (int i = 0; i < 5; i++) cyc(1000, 1, 0, 0);
      chk("ena_hold_data", int'(o_data), hold_d);
      chk("ena_hold_e1", int'(dut.e1_q), hold_e1);
      chk("ena_hold_cnt", int'(dut.cnt_q), hold_cnt);
      for (int i = 0; i < 10; i++) cyc(1000, 1, 1, 0);

      // Reset mid-stream, then restart from power-up behaviour.
      rst_an = 1'b0;
      model_reset();
      #1;
      chk("midrst_o_data", int'(o_data), 0);
      chk("midrst_o_valid", int'(o_valid), 0);
      @(posedge clk); #1;
      rst_an = 1'b1;
      cyc(1000, 1, 1, 0);
      cyc(1000, 1, 1, 0);
      cyc(1000, 1, 1, 0);
      chk("midrst_e_s3", int'(dut.e1_q), -1904);
      cyc(0, 0, 1, 0);

      // Negative full scale never wraps or overloads.
      do_reset();
      for (int i = 0; i < 20; i++) cyc(-32768, 1, 1, 0);
      chk("negfs_data", int'(o_data), -8);
      chk("negfs_ovl", int'(o_ovl), 0);
      cyc(0, 0, 1, 0);

      // Positive full scale: saturation, recovery and sticky flag.
      do_reset();
      cyc(32767, 1, 1, 0);
      chk("posfs_e_s1", int'(dut.e1_q), -4095);
      for (int i = 1; i < 8; i++) cyc(32767, 1, 1, 0);
      chk("ovl_before_limit", int'(o_ovl), 0);
      cyc(32767, 1, 1, 0);
      chk("ovl_at_limit", int'(o_ovl), 1);
      cyc(32767, 1, 1, 0);
      chk("recover_e1", int'(dut.e1_q), -4095);
      chk("recover_e2", int'(dut.e2_q), 0);
      cyc(32767, 1, 1, 0);
      chk("ovl_sticky", int'(o_ovl), 1);
      cyc(32767, 1, 1, 1);
      chk("ovl_clr", int'(o_ovl), 0);
      for (int i = 13; i < 18; i++) cyc(32767, 1, 1, 0);
      chk("ovl_low_before_2nd", int'(o_ovl), 0);
      cyc(32767, 1, 1, 1);
      chk("ovl_set_wins", int'(o_ovl), 1);
      for (int i = 0; i < 12; i++) cyc(32767, 1, 1, 0);
      cyc(0, 0, 1, 0);
      cyc(0, 0, 1, 0);

      chk("sb_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
